object_compositor: RTL and testbench
====================================

# object_compositor

Parametrised N-object pixel compositor for the VGA path. Sits between the game-state logic and the VGA controller: per pixel, it tests DrawX/DrawY against N_OBJ rectangle or circle objects and outputs the colour of the highest-priority hit, or the background colour. It also accumulates pairwise pixel-overlap collisions over each frame. Object attributes are shadowed at frame start so mid-frame updates cannot tear.

## Interface
Parameters:
- N_OBJ, 8, number of objects; index 0 is the highest priority.
- COORD_W, 10, coordinate and size width.
- BG_COLOR, 24'h70707F, background colour {R,G,B}, used in the visible area.

Ports:
- Clk  in  1  pixel clock; single clock domain.
- Reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse, asserted only while blank=0; latches shadows and publishes collisions.
- DrawX, DrawY  in  COORD_W each  current pixel.
- blank  in  1  1 = visible pixel, 0 = blanking.
- obj_x, obj_y  in  N_OBJ×COORD_W  object centres.
- obj_hw, obj_hh  in  N_OBJ×COORD_W  half-width and half-height; circles use obj_hw as the radius.
- obj_shape  in  N_OBJ  0 = rect, 1 = circle.
- obj_en  in  N_OBJ  object enable.
- obj_color  in  N_OBJ×24  {R,G,B}.
- Red, Green, Blue  out  8 each  registered pixel colour.
- hit_any  out  1  an enabled object covers the output pixel.
- hit_id  out  $clog2(N_OBJ)  winning index; 0 when hit_any=0.
- coll_mask  out  N_OBJ×N_OBJ  frame collision matrix; bit [i][j] is set for i<j only.
- coll_valid  out  1  one-cycle pulse when coll_mask updates.

## Operation
- **Shadowing.** When frame_start=1, all obj_* inputs are copied into shadow registers. Only the shadow values are used for hit tests. Shadows reset to 0, so no object is enabled after reset.
- **Rectangle hit.**
  - Compute dx = DrawX − x and dy = DrawY − y as signed COORD_W+1 values.
  - Hit when |dx| ≤ hw and |dy| ≤ hh.
  - No unsigned wrap: an object at x=3, hw=5 covers DrawX 0..8 only.
- **Circle hit.** Hit when dx²+dy² ≤ hw². Squares are 2·(COORD_W+1) bits wide, and the sum is one bit wider.
- A hit requires the object's shadow enable = 1.
- **Priority.** The lowest set index among hits wins.
  - Output colour = obj_color of the winner.
  - Else BG_COLOR if blank=1.
  - Else 0 when blank=0, which overrides objects.
  - hit_any and hit_id are still reported while blank=0, but collisions are not accumulated.
- **Collision accumulation.** On a visible pixel with hits on i and j (i<j), set acc[i][j]. Accumulation is sticky for the rest of the frame.
- **Collision publication.** On frame_start:
  - coll_mask ← acc, and acc is cleared.
  - Clearing has priority over any same-cycle set.
  - coll_valid pulses on the following cycle.
- **Reset mid-frame.** Clears the pipeline, acc, coll_mask and shadows. Outputs return to reset values on the next edge.

## Timing
- Latency: DrawX/DrawY/blank at cycle t → Red/Green/Blue/hit_* valid at the edge ending cycle t+3. blank is delayed alongside the coordinates.
- Pipeline stages:
  - S1: register dx, dy and |dx|, |dy|.
  - S2: register products, comparisons and the per-object hit vector.
  - S3: register priority select, colour and collision set.
- Throughput: one pixel per clock, no stalls.
- Shadow update takes effect for pixels entering S1 at t+1 after frame_start. Pixels already in flight use the old values; this is harmless because they are in blanking.
- coll_mask is stable between coll_valid pulses.
- Reset values: Red = Green = Blue = 0, hit_any = 0, hit_id = 0, coll_mask = 0, coll_valid = 0.

## Structure
- Package compositor_pkg holds:
  - COORD_W default;
  - shape_t enum {SHAPE_RECT, SHAPE_CIRCLE};
  - rgb_t packed struct {r,g,b};
  - obj_attr_t struct {x, y, hw, hh, shape, en, color}.
- Sub-module obj_hit_test, one instance per object, implements S1–S2 and outputs a 1-bit hit. The top level handles the shadows, priority encoder, colour mux and collision matrix.

## Test plan
- **Reset:** Reset=1 for 2 cycles → RGB 0, coll_mask 0, hit_any 0; with objects driven but no frame_start, every visible pixel → BG 70/70/7F.
- **Rectangle edges:** obj0 rect x=100, y=100, hw=4, hh=2, color FF0000, frame_start; sweep DrawX 95..105 at Y=100 → red exactly for 96..104, 3 cycles after each input pixel. A Y of 97 → background.
- **Circle and no-wrap:** obj1 circle x=2, y=2, r=5. Pixel (5,6): 9+16=25 → hit. Pixel (6,6): 32 → miss. Pixel (1023,2) → miss.
- **Priority and blank:** obj0 and obj3 overlap at (200,200) → obj0 colour, hit_id=0. Same pixel with blank=0 → RGB 0, hit_id=0. Disable obj0 at the next frame_start → obj3 colour.
- **Collision:** obj2 and obj5 overlap on visible pixels during frame N; obj1 and obj2 overlap only during blank.
  - Frame_start after frame N → coll_valid pulse; only bit [2][5] is set.
  - Following frame with no overlap → coll_mask 0.
- **Tear-free:** change obj0_x mid-frame without frame_start → the output is unchanged until after the next frame_start.

Source files
------------

// File: rtl/compositor_pkg.sv
// Shared types for the object compositor: object shapes, colours and the
// per-object attribute record that the top level shadows once per frame.
package compositor_pkg;
  localparam int DEF_COORD_W = 10;

  typedef enum logic {
    SHAPE_RECT   = 1'b0,
    SHAPE_CIRCLE = 1'b1
  } shape_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
    logic [DEF_COORD_W-1:0] hw;
    logic [DEF_COORD_W-1:0] hh;
    shape_t                 shape;
    logic                   en;
    rgb_t                   color;
  } obj_attr_t;
endpackage

// File: rtl/obj_hit_test.sv
// Two-stage hit test of one object against the current pixel.
// S1 registers |dx|, |dy| and the object's size/shape/enable; S2 registers the hit.
module obj_hit_test
  import compositor_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] hw,
  input  logic [COORD_W-1:0] hh,
  input  shape_t             shape,
  input  logic               en,
  output logic               hit
);
  localparam int SW = COORD_W + 1;
  localparam int PW = 2 * SW;

  // Extending both operands by a zero bit makes the difference a true signed
  // distance, so objects near the screen edge never wrap around.
  logic signed [SW-1:0] dx, dy;
  logic [SW-1:0] adx_c, ady_c;
  assign dx    = $signed({1'b0, draw_x}) - $signed({1'b0, x});
  assign dy    = $signed({1'b0, draw_y}) - $signed({1'b0, y});
  assign adx_c = dx[SW-1] ? $unsigned(-dx) : $unsigned(dx);
  assign ady_c = dy[SW-1] ? $unsigned(-dy) : $unsigned(dy);

  logic [SW-1:0]      adx, ady;
  logic [COORD_W-1:0] hw_s1, hh_s1;
  shape_t             shape_s1;
  logic               en_s1;

  logic [PW-1:0] dx2, dy2, r2;
  logic [PW:0]   dist2;
  logic          in_rect, in_circ;

  always_comb begin
    dx2     = {{SW{1'b0}}, adx} * {{SW{1'b0}}, adx};
    dy2     = {{SW{1'b0}}, ady} * {{SW{1'b0}}, ady};
    r2      = {{(PW-COORD_W){1'b0}}, hw_s1} * {{(PW-COORD_W){1'b0}}, hw_s1};
    dist2   = {1'b0, dx2} + {1'b0, dy2};
    in_circ = dist2 <= {1'b0, r2};
    in_rect = (adx <= {1'b0, hw_s1}) && (ady <= {1'b0, hh_s1});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      adx      <= '0;
      ady      <= '0;
      hw_s1    <= '0;
      hh_s1    <= '0;
      shape_s1 <= SHAPE_RECT;
      en_s1    <= 1'b0;
      hit      <= 1'b0;
    end else begin
      adx      <= adx_c;
      ady      <= ady_c;
      hw_s1    <= hw;
      hh_s1    <= hh;
      shape_s1 <= shape;
      en_s1    <= en;
      hit      <= en_s1 && ((shape_s1 == SHAPE_CIRCLE) ? in_circ : in_rect);
    end
  end
endmodule

// File: rtl/object_compositor.sv
// N-object pixel compositor: frame-shadowed object attributes, per-object hit
// tests, priority colour select and a per-frame pairwise collision matrix.
module object_compositor
  import compositor_pkg::*;
#(
  parameter int          N_OBJ    = 8,
  parameter int          COORD_W  = DEF_COORD_W,
  parameter logic [23:0] BG_COLOR = 24'h70707F
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            frame_start,
  input  logic [COORD_W-1:0]              DrawX,
  input  logic [COORD_W-1:0]              DrawY,
  input  logic                            blank,
  input  logic [N_OBJ-1:0][COORD_W-1:0]   obj_x,
  input  logic [N_OBJ-1:0][COORD_W-1:0]   obj_y,
  input  logic [N_OBJ-1:0][COORD_W-1:0]   obj_hw,
  input  logic [N_OBJ-1:0][COORD_W-1:0]   obj_hh,
  input  logic [N_OBJ-1:0]                obj_shape,
  input  logic [N_OBJ-1:0]                obj_en,
  input  logic [N_OBJ-1:0][23:0]          obj_color,
  output logic [7:0]                      Red,
  output logic [7:0]                      Green,
  output logic [7:0]                      Blue,
  output logic                            hit_any,
  output logic [$clog2(N_OBJ)-1:0]        hit_id,
  output logic [N_OBJ-1:0][N_OBJ-1:0]     coll_mask,
  output logic                            coll_valid
);
  localparam int IW = $clog2(N_OBJ);

  obj_attr_t                     sh [N_OBJ];
  logic [N_OBJ-1:0]              hit_v;
  logic                          blank_s1, blank_s2;
  logic [N_OBJ-1:0][N_OBJ-1:0]   acc, set_m;
  logic [IW-1:0]                 win;
  logic                          any;
  rgb_t                          pix;

  for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
    obj_hit_test #(.COORD_W(COORD_W)) u_hit (
      .clk    (Clk),
      .reset  (Reset),
      .draw_x (DrawX),
      .draw_y (DrawY),
      .x      (sh[g].x),
      .y      (sh[g].y),
      .hw     (sh[g].hw),
      .hh     (sh[g].hh),
      .shape  (sh[g].shape),
      .en     (sh[g].en),
      .hit    (hit_v[g])
    );
  end

  // Descending scan so the lowest hit index is the last (winning) assignment.
  always_comb begin
    win   = '0;
    any   = 1'b0;
    set_m = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hit_v[i]) begin
        win = IW'(i);
        any = 1'b1;
      end
      for (int j = i + 1; j < N_OBJ; j++) set_m[i][j] = hit_v[i] & hit_v[j];
    end
    pix = '0;
    if (blank_s2) pix = any ? sh[win].color : rgb_t'(BG_COLOR);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_OBJ; i++) sh[i] <= '0;
      blank_s1   <= 1'b0;
      blank_s2   <= 1'b0;
      acc        <= '0;
      coll_mask  <= '0;
      coll_valid <= 1'b0;
      hit_any    <= 1'b0;
      hit_id     <= '0;
      Red        <= '0;
      Green      <= '0;
      Blue       <= '0;
    end else begin
      // Publishing clears the accumulator even if a set would land this cycle.
      if (frame_start) begin
        for (int i = 0; i < N_OBJ; i++) begin
          sh[i].x     <= obj_x[i];
          sh[i].y     <= obj_y[i];
          sh[i].hw    <= obj_hw[i];
          sh[i].hh    <= obj_hh[i];
          sh[i].shape <= shape_t'(obj_shape[i]);
          sh[i].en    <= obj_en[i];
          sh[i].color <= rgb_t'(obj_color[i]);
        end
        coll_mask <= acc;
        acc       <= '0;
      end else if (blank_s2) begin
        acc <= acc | set_m;
      end
      coll_valid <= frame_start;
      blank_s1   <= blank;
      blank_s2   <= blank_s1;
      hit_any    <= any;
      hit_id     <= win;
      Red        <= pix.r;
      Green      <= pix.g;
      Blue       <= pix.b;
    end
  end
endmodule

// File: tb/tb_object_compositor.sv
// Directed bench for object_compositor: hand-computed pixels, priorities,
// collision frames, shadowing and reset behaviour.
module tb_object_compositor;
  localparam int N = 8;
  localparam logic [23:0] BG = 24'h70707F;

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic                 frame_start;
  logic [9:0]           DrawX, DrawY;
  logic                 blank;
  logic [N-1:0][9:0]    obj_x, obj_y, obj_hw, obj_hh;
  logic [N-1:0]         obj_shape, obj_en;
  logic [N-1:0][23:0]   obj_color;
  logic [7:0]           Red, Green, Blue;
  logic                 hit_any;
  logic [2:0]           hit_id;
  logic [N-1:0][N-1:0]  coll_mask;
  logic                 coll_valid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_c;
  logic        fs_valid, fs_valid_after;
  logic [63:0] fs_mask;

  object_compositor dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .obj_x(obj_x), .obj_y(obj_y), .obj_hw(obj_hw), .obj_hh(obj_hh),
    .obj_shape(obj_shape), .obj_en(obj_en), .obj_color(obj_color),
    .Red(Red), .Green(Green), .Blue(Blue),
    .hit_any(hit_any), .hit_id(hit_id),
    .coll_mask(coll_mask), .coll_valid(coll_valid)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // driver: hold one pixel until it has crossed all three stages
  task automatic px(input int x, input int y, input logic b);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  // driver: a few blanking cycles, then a frame_start pulse
  task automatic frame_pulse();
    @(negedge Clk);
    blank = 1'b0;
    repeat (3) @(negedge Clk);
    frame_start = 1'b1;
    @(posedge Clk);
    #1;
    fs_valid = coll_valid;
    fs_mask  = coll_mask;
    @(negedge Clk);
    frame_start = 1'b0;
    @(posedge Clk);
    #1;
    fs_valid_after = coll_valid;
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int hw,
                         input int hh, input logic circ, input logic en,
                         input logic [23:0] col);
    obj_x[i] = 10'(x);  obj_y[i] = 10'(y);
    obj_hw[i] = 10'(hw); obj_hh[i] = 10'(hh);
    obj_shape[i] = circ; obj_en[i] = en; obj_color[i] = col;
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; blank = 1'b0;
    DrawX = '0; DrawY = '0;
    obj_x = '0; obj_y = '0; obj_hw = '0; obj_hh = '0;
    obj_shape = '0; obj_en = '0; obj_color = '0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check("reset_rgb", {Red, Green, Blue}, 24'h0);
    check("reset_hit_any", hit_any, 1'b0);
    check("reset_hit_id", hit_id, 3'd0);
    check("reset_coll_mask", coll_mask, 64'h0);
    check("reset_coll_valid", coll_valid, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;

    // Objects driven but never latched: background only
    set_obj(0, 100, 100, 4, 2, 1'b0, 1'b1, 24'hFF0000);
    px(100, 100, 1'b1);
    check("no_shadow_bg", {Red, Green, Blue}, BG);
    check("no_shadow_hit_any", hit_any, 1'b0);

    // Rectangle edges, streamed one pixel per clock
    frame_pulse();
    exp_q.delete();
    for (int c = 0; c < 13; c++) begin
      @(negedge Clk);
      if (c < 11) begin
        DrawX = 10'(95 + c);
        DrawY = 10'd100;
        blank = 1'b1;
        exp_q.push_back(((95 + c) >= 96 && (95 + c) <= 104) ? 24'hFF0000 : BG);
      end
      @(posedge Clk);
      #1;
      if (c >= 2) begin
        exp_c = exp_q.pop_front();
        check($sformatf("rect_sweep_x%0d", 95 + c - 2), {Red, Green, Blue}, exp_c);
      end
    end
    px(100, 97, 1'b1);
    check("rect_y_outside", {Red, Green, Blue}, BG);
    px(100, 98, 1'b1);
    check("rect_y_edge", {Red, Green, Blue}, 24'hFF0000);

    // Circle and no-wrap
    set_obj(1, 2, 2, 5, 0, 1'b1, 1'b1, 24'h00FF00);
    frame_pulse();
    px(5, 6, 1'b1);
    check("circle_r2_edge", {Red, Green, Blue}, 24'h00FF00);
    check("circle_hit_id", hit_id, 3'd1);
    px(6, 6, 1'b1);
    check("circle_outside", {Red, Green, Blue}, BG);
    px(1023, 2, 1'b1);
    check("circle_no_wrap", {Red, Green, Blue}, BG);
    px(0, 0, 1'b1);
    check("circle_neg_dxdy", {Red, Green, Blue}, 24'h00FF00);

    // Priority and blank
    set_obj(0, 200, 200, 3, 3, 1'b0, 1'b1, 24'hFF0000);
    set_obj(3, 200, 200, 10, 10, 1'b0, 1'b1, 24'h0000FF);
    frame_pulse();
    px(200, 200, 1'b1);
    check("prio_color", {Red, Green, Blue}, 24'hFF0000);
    check("prio_hit_id", hit_id, 3'd0);
    check("prio_hit_any", hit_any, 1'b1);
    px(205, 200, 1'b1);
    check("prio_obj3_only", {Red, Green, Blue}, 24'h0000FF);
    check("prio_obj3_id", hit_id, 3'd3);
    px(200, 200, 1'b0);
    check("blank_rgb", {Red, Green, Blue}, 24'h0);
    check("blank_hit_id", hit_id, 3'd0);
    check("blank_hit_any", hit_any, 1'b1);
    obj_en[0] = 1'b0;
    frame_pulse();
    check("prio_frame_valid", fs_valid, 1'b1);
    check("prio_frame_mask", fs_mask, 64'h8);
    check("prio_frame_valid_pulse", fs_valid_after, 1'b0);
    px(200, 200, 1'b1);
    check("prio_disabled_obj0", {Red, Green, Blue}, 24'h0000FF);
    check("prio_disabled_id", hit_id, 3'd3);

    // Collision: 2/5 overlap visibly, 1/2 overlap only in blanking
    obj_en = '0;
    set_obj(1, 296, 306, 2, 2, 1'b0, 1'b1, 24'hABCDEF);
    set_obj(2, 300, 300, 5, 5, 1'b0, 1'b1, 24'h112233);
    set_obj(5, 304, 300, 5, 5, 1'b0, 1'b1, 24'h445566);
    frame_pulse();
    check("coll_prev_frame_empty", fs_mask, 64'h0);
    px(302, 300, 1'b1);
    check("coll_pixel_color", {Red, Green, Blue}, 24'h112233);
    check("coll_pixel_id", hit_id, 3'd2);
    px(296, 305, 1'b0);
    check("coll_blank_id", hit_id, 3'd1);
    check("coll_blank_rgb", {Red, Green, Blue}, 24'h0);
    check("coll_mask_stable", coll_mask, 64'h0);
    frame_pulse();
    check("coll_valid", fs_valid, 1'b1);
    check("coll_mask_2_5", fs_mask, 64'h0000_0000_0020_0000);
    check("coll_valid_one_cycle", fs_valid_after, 1'b0);
    px(0, 0, 1'b1);
    check("coll_no_overlap_bg", {Red, Green, Blue}, BG);
    frame_pulse();
    check("coll_clear_valid", fs_valid, 1'b1);
    check("coll_clear_mask", fs_mask, 64'h0);

    // Tear-free shadowing
    set_obj(0, 100, 100, 4, 2, 1'b0, 1'b1, 24'hFF0000);
    frame_pulse();
    px(100, 100, 1'b1);
    check("tear_before", {Red, Green, Blue}, 24'hFF0000);
    obj_x[0] = 10'd500;
    px(100, 100, 1'b1);
    check("tear_mid_frame", {Red, Green, Blue}, 24'hFF0000);
    frame_pulse();
    px(100, 100, 1'b1);
    check("tear_after_old", {Red, Green, Blue}, BG);
    px(500, 100, 1'b1);
    check("tear_after_new", {Red, Green, Blue}, 24'hFF0000);

    // Reset mid-frame
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("midreset_rgb", {Red, Green, Blue}, 24'h0);
    check("midreset_hit_any", hit_any, 1'b0);
    check("midreset_coll_mask", coll_mask, 64'h0);
    @(negedge Clk);
    Reset = 1'b0;
    px(500, 100, 1'b1);
    check("midreset_shadow_cleared", {Red, Green, Blue}, BG);
    check("midreset_shadow_hit_any", hit_any, 1'b0);

    // final report
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
